// File: rtl/csi_tx_lane_distributor.sv
// CSI-2 TX lane distributor: wraps striped packet words into per-lane HS bursts
// (SYNC, payload, trail, gap) with a programmable 0..2 byte-clock skew per lane.
package top_pkg;
  localparam int NUM_LANE = 2;
endpackage

module csi_tx_lane_distributor
  import top_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         TRAIL_CYCLES = 2,
  parameter int         GAP_CYCLES   = 4
) (
  input  logic                          byte_clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_LANE*8-1:0]         in_data,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [$clog2(NUM_LANE+1)-1:0] in_nbytes,
  output logic                          in_ready,
  input  logic [2*NUM_LANE-1:0]         lane_skew,
  output logic [NUM_LANE*8-1:0]         word_out,
  output logic [NUM_LANE-1:0]           valid_out,
  output logic                          busy,
  output logic                          underrun_err
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, TRAIL, GAP} state_t;

  state_t                   state, state_nxt;
  logic [3:0]               count, count_nxt;
  logic [2*NUM_LANE-1:0]    skew_cap;
  logic                     capture, underrun_set;
  logic [NUM_LANE*8-1:0]    last_bytes, last_nxt;
  logic [NUM_LANE*8-1:0]    pre_data;
  logic [NUM_LANE-1:0]      pre_vld;
  logic [NUM_LANE*8-1:0]    data_p0, data_p1, data_p2, sel_data;
  logic [NUM_LANE-1:0]      vld_p0, vld_p1, vld_p2, sel_vld;

  // Trail polarity is the complement of the lane's last bit so the line toggles.
  function automatic logic [7:0] trail_byte(input logic [7:0] b);
    return b[7] ? 8'h00 : 8'hFF;
  endfunction

  assign in_ready = enable && (state == DATA);
  assign busy     = (state != IDLE) || (|vld_p0) || (|vld_p1) || (|vld_p2);

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    capture      = 1'b0;
    underrun_set = 1'b0;
    pre_data     = '0;
    pre_vld      = '0;
    last_nxt     = last_bytes;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SYNC;
          capture   = 1'b1;
        end
      end
      SYNC: begin
        pre_data  = {NUM_LANE{SYNC_BYTE}};
        pre_vld   = '1;
        last_nxt  = {NUM_LANE{SYNC_BYTE}};
        state_nxt = DATA;
      end
      DATA: begin
        pre_vld = '1;
        if (in_valid) begin
          for (int i = 0; i < NUM_LANE; i++) begin
            if (!in_last || int'(in_nbytes) > i) begin
              pre_data[i*8 +: 8] = in_data[i*8 +: 8];
              last_nxt[i*8 +: 8] = in_data[i*8 +: 8];
            end else begin
              pre_data[i*8 +: 8] = trail_byte(last_bytes[i*8 +: 8]);
            end
          end
          if (in_last) begin
            state_nxt = TRAIL;
            count_nxt = 4'(TRAIL_CYCLES);
          end
        end else begin
          // Underrun keeps the burst alive with zero filler rather than stalling.
          underrun_set = 1'b1;
        end
      end
      TRAIL: begin
        pre_vld = '1;
        for (int i = 0; i < NUM_LANE; i++)
          pre_data[i*8 +: 8] = trail_byte(last_bytes[i*8 +: 8]);
        if (count == 4'd1) begin
          state_nxt = GAP;
          count_nxt = 4'(GAP_CYCLES);
        end else begin
          count_nxt = count - 4'd1;
        end
      end
      GAP: begin
        if (count == 4'd1) state_nxt = IDLE;
        else               count_nxt = count - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0 is the pre-skew register; stages 1 and 2 add one byte clock each.
  always_comb begin
    sel_data = '0;
    sel_vld  = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      case (skew_cap[2*i +: 2])
        2'd0: begin
          sel_data[i*8 +: 8] = data_p0[i*8 +: 8];
          sel_vld[i]         = vld_p0[i];
        end
        2'd1: begin
          sel_data[i*8 +: 8] = data_p1[i*8 +: 8];
          sel_vld[i]         = vld_p1[i];
        end
        default: begin
          sel_data[i*8 +: 8] = data_p2[i*8 +: 8];
          sel_vld[i]         = vld_p2[i];
        end
      endcase
    end
  end

  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      skew_cap     <= '0;
      underrun_err <= 1'b0;
      data_p0      <= '0;
      data_p1      <= '0;
      data_p2      <= '0;
      vld_p0       <= '0;
      vld_p1       <= '0;
      vld_p2       <= '0;
      word_out     <= '0;
      valid_out    <= '0;
    end else if (enable) begin
      state        <= state_nxt;
      count        <= count_nxt;
      if (capture) skew_cap <= lane_skew;
      underrun_err <= underrun_err | underrun_set;
      data_p0      <= pre_data;
      data_p1      <= data_p0;
      data_p2      <= data_p1;
      vld_p0       <= pre_vld;
      vld_p1       <= vld_p0;
      vld_p2       <= vld_p1;
      word_out     <= sel_data;
      valid_out    <= sel_vld;
    end
  end

  always_ff @(posedge byte_clock) begin
    if (enable) last_bytes <= last_nxt;
  end

endmodule
